tile_layer_renderer: RTL and testbench

Parametrised, pipelined successor to the two-layer tile sprite renderer: walks the VGA raster, fetches each tile's word from the state RAM, reads one sprite-sheet pixel per layer and composites LAYERS layers with a transparent key. It also runs the animation-frame counter internally and an optional full-screen flash effect. It sits between the VGA timing generator and the video output, with the state RAM, sprite ROMs and palette as external synchronous or combinational resources.

---
 rtl/tile_layer_renderer.sv | 179 +++++++++++++++++
 tb/tb_tile_layer_renderer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_layer_renderer.sv
// Pipelined multi-layer tile renderer: S0 map lookup, S1 sprite ROM addressing, S2 compositing, S3 output.
// Optional full-screen flash effect is built when TILE_RENDER_FLASH_EN is defined.
module tile_layer_renderer #(
    parameter int          TILE         = 24,
    parameter int          MAP_W        = 26,
    parameter int          MAP_H        = 16,
    parameter int          MAP_AW       = 10,
    parameter int          LAYERS       = 2,
    parameter int          SPR_W        = 11,
    parameter int          STATE_W      = 32,
    parameter int          SHEET_W      = 720,
    parameter int          ROM_AW       = 16,
    parameter int          ANIM_FRAMES  = 3,
    parameter int          ANIM_DIV     = 8,
    parameter logic [3:0]  TRANSPARENT  = 4'h1,
    parameter logic [11:0] BG_RGB       = 12'h220,
    parameter int          FLASH_FRAMES = 6
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic                     blank,
    input  logic                     frame_start,
    input  logic                     flash_req,
    output logic [MAP_AW-1:0]        state_ram_addr,
    input  logic [STATE_W-1:0]       state_ram_data,
    output logic [LAYERS*ROM_AW-1:0] rom_addr,
    input  logic [LAYERS*4-1:0]      rom_data,
    output logic [3:0]               pal_index,
    input  logic [11:0]              pal_rgb,
    output logic [1:0]               anim_frame,
    output logic                     flash_active,
    output logic [3:0]               red,
    output logic [3:0]               green,
    output logic [3:0]               blue
);

    localparam logic [9:0] TILE_V = 10'(TILE);
    localparam int         USED_W = 10 + LAYERS * SPR_W;
    localparam int         DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [9:0] tile_x, tile_y;
    logic       s1_valid, s1_blank, s1_oob;
    logic [9:0] s1_px, s1_py;
    logic       s2_valid, s2_blank, s2_oob;
    logic [LAYERS*ROM_AW-1:0] rom_addr_next;
    logic       found;
    logic [11:0] colour, shade;
    logic [DIV_W-1:0] div_cnt;

    // The low 10 bits of the tile word (and any spare top bits) carry no layer data here.
    logic unused_state_lo;
    assign unused_state_lo = ^state_ram_data[9:0];
    generate
        if (STATE_W > USED_W) begin : g_spare
            logic unused_state_hi;
            assign unused_state_hi = ^state_ram_data[STATE_W-1:USED_W];
        end
    endgenerate

    assign tile_x         = DrawX / TILE_V;
    assign tile_y         = DrawY / TILE_V;
    assign state_ram_addr = MAP_AW'(32'(tile_y) * MAP_W + 32'(tile_x));

    always_ff @(posedge vga_clk) begin
        if (!reset_n) s1_valid <= 1'b0;
        else          s1_valid <= 1'b1;
    end

    always_ff @(posedge vga_clk) begin
        s1_px    <= DrawX % TILE_V;
        s1_py    <= DrawY % TILE_V;
        s1_oob   <= (32'(DrawX) >= MAP_W * TILE) || (32'(DrawY) >= MAP_H * TILE);
        s1_blank <= blank;
    end

    // Uses the current anim_frame, so a frame_start this cycle affects the next pixel's addresses.
    always_comb begin
        rom_addr_next = '0;
        for (int k = 0; k < LAYERS; k++) begin
            rom_addr_next[k*ROM_AW +: ROM_AW] = ROM_AW'(
                32'(state_ram_data[10 + k*SPR_W +: SPR_W]) * TILE
                + 32'(s1_px) + 32'(s1_py) * SHEET_W
                + 32'(anim_frame) * SHEET_W * TILE);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_addr <= '0;
            s2_valid <= 1'b0;
        end else begin
            rom_addr <= rom_addr_next;
            s2_valid <= s1_valid;
        end
        s2_blank <= s1_blank;
        s2_oob   <= s1_oob;
    end

    // Ascending scan so the highest opaque layer wins.
    always_comb begin
        found     = 1'b0;
        pal_index = 4'h0;
        for (int k = 0; k < LAYERS; k++) begin
            if (rom_data[k*4 +: 4] != TRANSPARENT) begin
                found     = 1'b1;
                pal_index = rom_data[k*4 +: 4];
            end
        end
        if (s2_oob)     colour = 12'h000;
        else if (found) colour = pal_rgb;
        else            colour = BG_RGB;
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            anim_frame <= 2'd0;
        end else if (frame_start) begin
            if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt    <= '0;
                anim_frame <= (anim_frame == 2'(ANIM_FRAMES - 1)) ? 2'd0 : anim_frame + 2'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

`ifdef TILE_RENDER_FLASH_EN
    localparam int FCNT_W = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, ARMED, FLASH} flash_state_t;

    flash_state_t      flash_state, flash_next;
    logic [FCNT_W-1:0] fcnt, fcnt_next;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            flash_state <= IDLE;
            fcnt        <= '0;
        end else begin
            flash_state <= flash_next;
            fcnt        <= fcnt_next;
        end
    end

    always_comb begin
        flash_next = flash_state;
        fcnt_next  = fcnt;
        case (flash_state)
            IDLE:    if (flash_req) flash_next = ARMED;
            ARMED:   if (frame_start) begin
                         flash_next = FLASH;
                         fcnt_next  = FCNT_W'(FLASH_FRAMES);
                     end
            FLASH:   if (frame_start) begin
                         if (fcnt == FCNT_W'(1)) flash_next = IDLE;
                         fcnt_next = fcnt - FCNT_W'(1);
                     end
            default: flash_next = IDLE;
        endcase
    end

    assign flash_active = (flash_state == FLASH);
`else
    logic unused_flash_req;
    assign unused_flash_req = flash_req;
    assign flash_active     = 1'b0;
`endif

    assign shade = flash_active ? ~colour : colour;

    always_ff @(posedge vga_clk) begin
        if (!reset_n || !s2_valid || !s2_blank) {red, green, blue} <= 12'h000;
        else                                    {red, green, blue} <= shade;
    end

endmodule

// File: tb/tb_tile_layer_renderer.sv
// Directed, table-driven bench for tile_layer_renderer with hand-computed expected values.
// Flash checks adapt to whether TILE_RENDER_FLASH_EN is defined.
module tb_tile_layer_renderer;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank, frame_start, flash_req;
    logic [9:0]  state_ram_addr;
    logic [31:0] state_ram_data;
    logic [31:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  pal_index;
    logic [11:0] pal_rgb;
    logic [1:0]  anim_frame;
    logic        flash_active;
    logic [3:0]  red, green, blue;

    logic [31:0] ram_word;
    logic [3:0]  rom0_val, rom1_val;
    logic [11:0] pal [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  x, y;
        logic        blank;
        logic [31:0] word;
        logic [3:0]  rom0, rom1;
        logic [31:0] exp_ram, exp_a0, exp_a1, exp_rgb;
    } vec_t;

    vec_t vecs [9];

    tile_layer_renderer dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .flash_req(flash_req),
        .state_ram_addr(state_ram_addr), .state_ram_data(state_ram_data),
        .rom_addr(rom_addr), .rom_data(rom_data), .pal_index(pal_index),
        .pal_rgb(pal_rgb), .anim_frame(anim_frame), .flash_active(flash_active),
        .red(red), .green(green), .blue(blue)
    );

    always #5 vga_clk = ~vga_clk;

    // External resources: registered state RAM, per-layer ROM value, combinational palette.
    always @(posedge vga_clk) state_ram_data <= ram_word;
    assign rom_data = {rom1_val, rom0_val};
    assign pal_rgb  = pal[pal_index];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        DrawX    = v.x;
        DrawY    = v.y;
        blank    = v.blank;
        ram_word = v.word;
        rom0_val = v.rom0;
        rom1_val = v.rom1;
    endtask

    task automatic pulseInputs(input logic req, input logic fs);
        @(posedge vga_clk); #1;
        flash_req   = req;
        frame_start = fs;
        @(posedge vga_clk); #1;
        flash_req   = 1'b0;
        frame_start = 1'b0;
    endtask

    function automatic logic [31:0] rgbNow();
        return 32'({red, green, blue});
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) pal[i] = {4'(i), 4'(i + 1), 4'(i + 2)};
        pal[7] = 12'h5A3;

        vecs[0] = '{10'd30,  10'd50,  1'b1, 32'h00A00C00, 4'h7, 4'h1, 32'd53,  32'd1518,  32'd1566,  32'h5A3};
        vecs[1] = '{10'd30,  10'd50,  1'b1, 32'h00A00C00, 4'h1, 4'h1, 32'd53,  32'd1518,  32'd1566,  32'h220};
        vecs[2] = '{10'd47,  10'd23,  1'b1, 32'h00400400, 4'h7, 4'h9, 32'd1,   32'd16607, 32'd16631, 32'h9AB};
        vecs[3] = '{10'd623, 10'd383, 1'b1, 32'h00002800, 4'h2, 4'h1, 32'd415, 32'd16823, 32'd16583, 32'h234};
        vecs[4] = '{10'd624, 10'd10,  1'b1, 32'h00A00C00, 4'h7, 4'h1, 32'd26,  32'd7272,  32'd7320,  32'h000};
        vecs[5] = '{10'd5,   10'd384, 1'b1, 32'h00000000, 4'h7, 4'h7, 32'd416, 32'd5,     32'd5,     32'h000};
        vecs[6] = '{10'd30,  10'd50,  1'b0, 32'h00A00C00, 4'h7, 4'h1, 32'd53,  32'd1518,  32'd1566,  32'h000};
        vecs[7] = '{10'd100, 10'd200, 1'b1, 32'hFFE00000, 4'h0, 4'h1, 32'd212, 32'd5764,  32'd54892, 32'h012};
        vecs[8] = '{10'd639, 10'd479, 1'b1, 32'h00000000, 4'h7, 4'h7, 32'd520, 32'd16575, 32'd16575, 32'h000};

        reset_n = 1'b0; flash_req = 1'b0; frame_start = 1'b0;
        applyStimulus(vecs[0]);

        // Reset state, then first pixel appears exactly 3 edges after release.
        repeat (3) @(posedge vga_clk);
        #1;
        checkOutput("reset rgb", rgbNow(), 32'h0);
        checkOutput("reset rom_addr", rom_addr, 32'h0);
        checkOutput("reset anim_frame", 32'(anim_frame), 32'd0);
        checkOutput("reset flash_active", 32'(flash_active), 32'd0);
        reset_n = 1'b1;
        @(posedge vga_clk); #1;
        checkOutput("release edge1 rgb", rgbNow(), 32'h0);
        @(posedge vga_clk); #1;
        checkOutput("release edge2 rgb", rgbNow(), 32'h0);
        @(posedge vga_clk); #1;
        checkOutput("release edge3 rgb", rgbNow(), 32'h5A3);

        for (int i = 0; i < 9; i++) begin
            @(posedge vga_clk); #1;
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d state_ram_addr", i), 32'(state_ram_addr), vecs[i].exp_ram);
            repeat (3) @(posedge vga_clk);
            #1;
            checkOutput($sformatf("vec%0d rom_addr0", i), 32'(rom_addr[15:0]), vecs[i].exp_a0);
            checkOutput($sformatf("vec%0d rom_addr1", i), 32'(rom_addr[31:16]), vecs[i].exp_a1);
            checkOutput($sformatf("vec%0d rgb", i), rgbNow(), vecs[i].exp_rgb);
        end

        // A single active-video pixel must surface on exactly the third edge.
        applyStimulus(vecs[6]);
        repeat (4) @(posedge vga_clk);
        #1;
        checkOutput("latency idle rgb", rgbNow(), 32'h0);
        blank = 1'b1;
        @(posedge vga_clk); #1;
        blank = 1'b0;
        checkOutput("latency edge1 rgb", rgbNow(), 32'h0);
        @(posedge vga_clk); #1;
        checkOutput("latency edge2 rgb", rgbNow(), 32'h0);
        @(posedge vga_clk); #1;
        checkOutput("latency edge3 rgb", rgbNow(), 32'h5A3);
        @(posedge vga_clk); #1;
        checkOutput("latency edge4 rgb", rgbNow(), 32'h0);

        for (int k = 1; k <= 24; k++) begin
            pulseInputs(1'b0, 1'b1);
            checkOutput($sformatf("anim after pulse %0d", k), 32'(anim_frame), 32'((k / 8) % 3));
        end

        // Seven more pulses, then the eighth coincides with lookups of a held pixel.
        DrawX = 10'd30; DrawY = 10'd50; blank = 1'b1;
        ram_word = 32'h00400000; rom0_val = 4'h7; rom1_val = 4'h1;
        for (int k = 0; k < 7; k++) pulseInputs(1'b0, 1'b0 | 1'b1);
        repeat (3) @(posedge vga_clk);
        #1;
        checkOutput("anim0 rom_addr1", 32'(rom_addr[31:16]), 32'd1494);
        frame_start = 1'b1;
        @(posedge vga_clk); #1;
        frame_start = 1'b0;
        checkOutput("coincide anim_frame", 32'(anim_frame), 32'd1);
        checkOutput("coincide old rom_addr1", 32'(rom_addr[31:16]), 32'd1494);
        @(posedge vga_clk); #1;
        checkOutput("anim1 state_ram_addr", 32'(state_ram_addr), 32'd53);
        checkOutput("anim1 rom_addr1", 32'(rom_addr[31:16]), 32'd18774);
        checkOutput("anim1 rom_addr0", 32'(rom_addr[15:0]), 32'd18726);

        applyStimulus(vecs[0]);
        repeat (4) @(posedge vga_clk);
        #1;
        checkOutput("pre-flash rgb", rgbNow(), 32'h5A3);

`ifdef TILE_RENDER_FLASH_EN
        pulseInputs(1'b1, 1'b0);
        checkOutput("armed flash_active", 32'(flash_active), 32'd0);
        pulseInputs(1'b0, 1'b1);
        checkOutput("flash start", 32'(flash_active), 32'd1);
        @(posedge vga_clk); #1;
        checkOutput("flash rgb inverted", rgbNow(), 32'hA5C);
        pulseInputs(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            pulseInputs(1'b0, 1'b1);
            checkOutput($sformatf("flash frame %0d", i), 32'(flash_active), 32'(i < 6));
        end
        pulseInputs(1'b0, 1'b1);
        checkOutput("second req ignored", 32'(flash_active), 32'd0);
        checkOutput("post-flash rgb", rgbNow(), 32'h5A3);
        pulseInputs(1'b1, 1'b1);
        checkOutput("req+fs arms only", 32'(flash_active), 32'd0);
        pulseInputs(1'b0, 1'b1);
        checkOutput("req+fs then flash", 32'(flash_active), 32'd1);
        @(posedge vga_clk); #1;
        reset_n = 1'b0;
        @(posedge vga_clk); #1;
        checkOutput("reset aborts flash", 32'(flash_active), 32'd0);
        reset_n = 1'b1;
        pulseInputs(1'b0, 1'b1);
        checkOutput("no flash after reset", 32'(flash_active), 32'd0);
`else
        pulseInputs(1'b1, 1'b0);
        pulseInputs(1'b0, 1'b1);
        checkOutput("flash disabled active", 32'(flash_active), 32'd0);
        @(posedge vga_clk); #1;
        checkOutput("flash disabled rgb", rgbNow(), 32'h5A3);
        pulseInputs(1'b1, 1'b1);
        pulseInputs(1'b0, 1'b1);
        checkOutput("flash disabled active 2", 32'(flash_active), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
